log_histogram: RTL and testbench

Parametrised logarithmic-bucket histogram for access-interval profiling in the sketch path. It bins each incoming sample into one of N_GROUPS×SUB_BINS counters: linear bins for small values, then groups whose bin width doubles. Counters live in an inferable RAM behind a 3-stage read-modify-write pipeline with forwarding. A valid/ready dump port streams the bins out, with optional clear-on-read, a drop counter, and a post-reset clear sweep.

---
 rtl/log_histogram.sv | 274 +++++++++++++++++++++++++++
 tb/tb_log_histogram.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/log_histogram.sv
// Logarithmic-bucket histogram: samples are binned into linear-then-doubling
// bins, counted in a RAM via a forwarding read-modify-write pipeline, and dumped over valid/ready.
module log_histogram #(
    parameter int SUB_BINS      = 8,
    parameter int N_GROUPS      = 8,
    parameter int INPUT_BITS    = 16,
    parameter int OUTPUT_BITS   = 32,
    parameter int CLEAR_ON_READ = 0,
    localparam int N_BINS       = N_GROUPS * SUB_BINS,
    localparam int IDX_W        = $clog2(N_BINS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_BITS-1:0]  sample_i,
    input  logic                   sample_valid_i,
    input  logic                   clear_req_i,
    input  logic                   dump_req_i,
    output logic                   busy_o,
    output logic [OUTPUT_BITS-1:0] dump_data_o,
    output logic [IDX_W-1:0]       dump_idx_o,
    output logic                   dump_valid_o,
    input  logic                   dump_ready_i,
    output logic                   dump_last_o,
    output logic [OUTPUT_BITS-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_DRAIN,
        ST_DUMP
    } state_t;

    localparam logic [OUTPUT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_BINS - 1);

    // Group g covers [SUB_BINS*(2^g-1), SUB_BINS*(2^(g+1)-1)); anything beyond the last group lands in the top bin.
    function automatic logic [IDX_W-1:0] binIndex(input logic [INPUT_BITS-1:0] s);
        logic [63:0]      d;
        logic [63:0]      lo;
        logic [63:0]      hi;
        logic [IDX_W-1:0] idx;
        d   = 64'(s);
        idx = LAST_IDX;
        for (int g = 0; g < N_GROUPS; g++) begin
            lo = 64'(SUB_BINS) * ((64'd1 << g) - 64'd1);
            hi = 64'(SUB_BINS) * ((64'd1 << (g + 1)) - 64'd1);
            if (d >= lo && d < hi) begin
                idx = IDX_W'(64'(g * SUB_BINS) + ((d - lo) >> g));
            end
        end
        return idx;
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       clrPtr_q, clrPtr_d;
    logic [1:0]             drainCnt_q, drainCnt_d;
    logic [OUTPUT_BITS-1:0] dropCnt_q, dropCnt_d;

    logic                   p0Valid_q, p0Valid_d;
    logic [IDX_W-1:0]       p0Idx_q, p0Idx_d;
    logic                   p1Valid_q, p1Valid_d;
    logic [IDX_W-1:0]       p1Idx_q, p1Idx_d;
    logic                   p2Valid_q, p2Valid_d;
    logic [IDX_W-1:0]       p2Idx_q, p2Idx_d;
    logic [OUTPUT_BITS-1:0] p2Cnt_q, p2Cnt_d;

    logic [IDX_W-1:0]       rdPtr_q, rdPtr_d;
    logic                   rdDone_q, rdDone_d;
    logic                   rdInflight_q, rdInflight_d;
    logic [IDX_W-1:0]       rdIdx_q, rdIdx_d;
    logic                   skidValid_q, skidValid_d;
    logic [OUTPUT_BITS-1:0] skidData_q, skidData_d;
    logic [IDX_W-1:0]       skidIdx_q, skidIdx_d;
    logic                   outValid_q, outValid_d;
    logic [OUTPUT_BITS-1:0] outData_q, outData_d;
    logic [IDX_W-1:0]       outIdx_q, outIdx_d;
    logic                   outLast_q, outLast_d;

    logic [OUTPUT_BITS-1:0] mem [N_BINS];
    logic [OUTPUT_BITS-1:0] ramQ;
    logic                   ramWe;
    logic [IDX_W-1:0]       ramWaddr;
    logic [IDX_W-1:0]       ramRaddr;
    logic [OUTPUT_BITS-1:0] ramWdata;

    logic                   sampleTake;
    logic                   dropInc;
    logic                   beatPop;
    logic                   issueWin;
    logic                   rdIssue;
    logic [1:0]             occ;
    logic [1:0]             occAfter;
    logic                   fwdHit;
    logic                   pipeWe;
    logic [OUTPUT_BITS-1:0] curCnt;
    logic [OUTPUT_BITS-1:0] incCnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clrPtr_q == LAST_IDX) state_d = ST_IDLE;
            ST_IDLE: begin
                if (clear_req_i)     state_d = ST_CLEAR;
                else if (dump_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (drainCnt_q == 2'd2) state_d = ST_DUMP;
            ST_DUMP:  if (beatPop && outIdx_q == LAST_IDX) state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        sampleTake = (state_q == ST_IDLE) && sample_valid_i;
        dropInc    = (state_q != ST_IDLE) && sample_valid_i;
        beatPop    = outValid_q && dump_ready_i;

        // The first dump read goes out in the last drain cycle so the beat lands right as DUMP begins.
        issueWin = (state_q == ST_DUMP) || (state_q == ST_DRAIN && drainCnt_q == 2'd2);
        occ      = {1'b0, outValid_q} + {1'b0, skidValid_q} + {1'b0, rdInflight_q};
        occAfter = occ - {1'b0, beatPop};
        rdIssue  = issueWin && !rdDone_q && (occAfter < 2'd2);

        fwdHit = p2Valid_q && (p2Idx_q == p1Idx_q);
        curCnt = fwdHit ? p2Cnt_q : ramQ;
        incCnt = (curCnt == CNT_MAX) ? curCnt : curCnt + 1'b1;
        pipeWe = p1Valid_q && (state_q != ST_CLEAR);

        // Entering CLEAR flushes in-flight samples so they cannot rewrite already-zeroed bins.
        p0Valid_d = sampleTake;
        p0Idx_d   = binIndex(sample_i);
        p1Valid_d = p0Valid_q && (state_q != ST_CLEAR);
        p1Idx_d   = p0Idx_q;
        p2Valid_d = pipeWe;
        p2Idx_d   = p1Idx_q;
        p2Cnt_d   = incCnt;

        ramWe    = 1'b0;
        ramWaddr = p1Idx_q;
        ramWdata = incCnt;
        if (state_q == ST_CLEAR) begin
            ramWe    = 1'b1;
            ramWaddr = clrPtr_q;
            ramWdata = '0;
        end else if (CLEAR_ON_READ != 0 && state_q == ST_DUMP && beatPop) begin
            ramWe    = 1'b1;
            ramWaddr = outIdx_q;
            ramWdata = '0;
        end else if (pipeWe) begin
            ramWe = 1'b1;
        end
        ramRaddr = rdIssue ? rdPtr_q : p0Idx_q;

        clrPtr_d   = (state_q == ST_CLEAR && clrPtr_q != LAST_IDX) ? clrPtr_q + 1'b1 : '0;
        drainCnt_d = (state_q == ST_DRAIN) ? drainCnt_q + 2'd1 : 2'd0;

        dropCnt_d = dropCnt_q;
        if (state_q == ST_IDLE && clear_req_i) begin
            dropCnt_d = '0;
        end else if (dropInc && dropCnt_q != CNT_MAX) begin
            dropCnt_d = dropCnt_q + 1'b1;
        end

        rdPtr_d  = rdPtr_q;
        rdDone_d = rdDone_q;
        if (state_q != ST_DRAIN && state_q != ST_DUMP) begin
            rdPtr_d  = '0;
            rdDone_d = 1'b0;
        end else if (rdIssue) begin
            if (rdPtr_q == LAST_IDX) rdDone_d = 1'b1;
            else                     rdPtr_d  = rdPtr_q + 1'b1;
        end
        rdInflight_d = rdIssue;
        rdIdx_d      = rdPtr_q;

        // Output register backed by a one-entry skid: the read credit check guarantees the skid is free whenever a read lands on a stalled output.
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        outIdx_d    = outIdx_q;
        outLast_d   = outLast_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        skidIdx_d   = skidIdx_q;
        if (!outValid_q || beatPop) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                outData_d   = skidData_q;
                outIdx_d    = skidIdx_q;
                outLast_d   = (skidIdx_q == LAST_IDX);
                skidValid_d = rdInflight_q;
                skidData_d  = ramQ;
                skidIdx_d   = rdIdx_q;
            end else if (rdInflight_q) begin
                outValid_d = 1'b1;
                outData_d  = ramQ;
                outIdx_d   = rdIdx_q;
                outLast_d  = (rdIdx_q == LAST_IDX);
            end else begin
                outValid_d = 1'b0;
                outLast_d  = 1'b0;
            end
        end else if (rdInflight_q) begin
            skidValid_d = 1'b1;
            skidData_d  = ramQ;
            skidIdx_d   = rdIdx_q;
        end
    end

    // Counter RAM: single write port, registered read returning the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramWaddr] <= ramWdata;
        end
        ramQ <= mem[ramRaddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clrPtr_q     <= '0;
            drainCnt_q   <= 2'd0;
            dropCnt_q    <= '0;
            p0Valid_q    <= 1'b0;
            p0Idx_q      <= '0;
            p1Valid_q    <= 1'b0;
            p1Idx_q      <= '0;
            p2Valid_q    <= 1'b0;
            p2Idx_q      <= '0;
            p2Cnt_q      <= '0;
            rdPtr_q      <= '0;
            rdDone_q     <= 1'b0;
            rdInflight_q <= 1'b0;
            rdIdx_q      <= '0;
            skidValid_q  <= 1'b0;
            skidData_q   <= '0;
            skidIdx_q    <= '0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            outIdx_q     <= '0;
            outLast_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clrPtr_q     <= clrPtr_d;
            drainCnt_q   <= drainCnt_d;
            dropCnt_q    <= dropCnt_d;
            p0Valid_q    <= p0Valid_d;
            p0Idx_q      <= p0Idx_d;
            p1Valid_q    <= p1Valid_d;
            p1Idx_q      <= p1Idx_d;
            p2Valid_q    <= p2Valid_d;
            p2Idx_q      <= p2Idx_d;
            p2Cnt_q      <= p2Cnt_d;
            rdPtr_q      <= rdPtr_d;
            rdDone_q     <= rdDone_d;
            rdInflight_q <= rdInflight_d;
            rdIdx_q      <= rdIdx_d;
            skidValid_q  <= skidValid_d;
            skidData_q   <= skidData_d;
            skidIdx_q    <= skidIdx_d;
            outValid_q   <= outValid_d;
            outData_q    <= outData_d;
            outIdx_q     <= outIdx_d;
            outLast_q    <= outLast_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign dump_valid_o = outValid_q;
    assign dump_data_o  = outData_q;
    assign dump_idx_o   = outIdx_q;
    assign dump_last_o  = outLast_q;
    assign drop_cnt_o   = dropCnt_q;

endmodule

// File: tb/tb_log_histogram.sv
// Directed bench for log_histogram: a default instance plus a 4-bit clear-on-read
// instance driven by the same stimulus, checked against hand-computed bin counts.
module tb_log_histogram;

    localparam int N_BINS = 64;

    typedef struct {
        logic [15:0] sample;
        int          expBin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_i;
    logic        sample_valid_i;
    logic        clear_req_i;
    logic        dump_req_i;
    logic        dump_ready_i;

    logic        aBusy, aValid, aLast;
    logic [31:0] aData, aDrop;
    logic [5:0]  aIdx;
    logic        bBusy, bValid, bLast;
    logic [3:0]  bData, bDrop;
    logic [5:0]  bIdx;

    int          nChecks = 0;
    int          nFails  = 0;
    int unsigned aBins [N_BINS];
    int unsigned bBins [N_BINS];
    int unsigned hist  [N_BINS];
    vec_t        vecs  [8];
    int          fwdSeq [8];
    int          n;

    log_histogram dutA (
        .clk(clk), .rst(rst),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .clear_req_i(clear_req_i), .dump_req_i(dump_req_i), .busy_o(aBusy),
        .dump_data_o(aData), .dump_idx_o(aIdx), .dump_valid_o(aValid),
        .dump_ready_i(dump_ready_i), .dump_last_o(aLast), .drop_cnt_o(aDrop)
    );

    log_histogram #(.OUTPUT_BITS(4), .CLEAR_ON_READ(1)) dutB (
        .clk(clk), .rst(rst),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .clear_req_i(clear_req_i), .dump_req_i(dump_req_i), .busy_o(bBusy),
        .dump_data_o(bData), .dump_idx_o(bIdx), .dump_valid_o(bValid),
        .dump_ready_i(dump_ready_i), .dump_last_o(bLast), .drop_cnt_o(bDrop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives `count` back-to-back valid samples starting at a negedge.
    task automatic applyStimulus(input int value, input int count);
        for (int i = 0; i < count; i++) begin
            sample_i       = 16'(value);
            sample_valid_i = 1'b1;
            @(negedge clk);
        end
        sample_valid_i = 1'b0;
    endtask

    task automatic measureBusy(output int cycles);
        cycles = 0;
        while (aBusy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    function automatic int nonzeroA();
        int c = 0;
        for (int i = 0; i < N_BINS; i++) if (aBins[i] != 0) c++;
        return c;
    endfunction

    function automatic int nonzeroB();
        int c = 0;
        for (int i = 0; i < N_BINS; i++) if (bBins[i] != 0) c++;
        return c;
    endfunction

    // readyMode 0: ready held high; 1: ready toggles. abortAfter >= 0 stops after that many accepted beats.
    task automatic runDump(input int readyMode, input int nDrop, input int abortAfter);
        int        beats     = 0;
        int        cyc       = 0;
        int        firstSeen = -1;
        logic      prevStall = 1'b0;
        logic [5:0]  prevIdx  = '0;
        logic [31:0] prevData = '0;
        for (int i = 0; i < N_BINS; i++) begin
            aBins[i] = 999;
            bBins[i] = 999;
        end
        dump_req_i = 1'b1;
        @(negedge clk);
        dump_req_i = 1'b0;
        while (beats < N_BINS && cyc < 400) begin
            cyc++;
            sample_i       = 16'd5;
            sample_valid_i = (cyc <= nDrop);
            dump_ready_i   = (readyMode == 0) ? 1'b1 : 1'(cyc % 2);
            if (prevStall) begin
                checkOutput("beat held under stall", longint'({aValid, aIdx, aData}),
                            longint'({1'b1, prevIdx, prevData}));
            end
            if (aValid) begin
                if (firstSeen < 0) firstSeen = cyc;
                if (dump_ready_i) begin
                    checkOutput("dump order", aIdx, beats);
                    checkOutput("dump last flag", aLast, (beats == N_BINS - 1) ? 1 : 0);
                    checkOutput("dump B index", bIdx, aIdx);
                    aBins[aIdx] = aData;
                    bBins[bIdx] = bData;
                    beats++;
                end
            end
            prevStall = aValid && !dump_ready_i;
            prevIdx   = aIdx;
            prevData  = aData;
            @(negedge clk);
            if (abortAfter >= 0 && beats >= abortAfter) break;
        end
        sample_valid_i = 1'b0;
        dump_ready_i   = 1'b0;
        checkOutput("dump first-beat latency", firstSeen, 5);
        if (abortAfter < 0) begin
            checkOutput("dump beat count", beats, N_BINS);
            checkOutput("busy after dump", aBusy, 0);
            checkOutput("valid after dump", aValid, 0);
        end
    endtask

    initial begin
        vecs[0] = '{16'd0,     0};
        vecs[1] = '{16'd7,     7};
        vecs[2] = '{16'd8,     8};
        vecs[3] = '{16'd23,    15};
        vecs[4] = '{16'd24,    16};
        vecs[5] = '{16'd2039,  63};
        vecs[6] = '{16'd2040,  63};
        vecs[7] = '{16'd65535, 63};
        fwdSeq  = '{3, 3, 3, 3, 3, 9, 9, 3};
        for (int i = 0; i < N_BINS; i++) hist[i] = 0;

        rst = 1'b1;
        sample_i = '0; sample_valid_i = 1'b0;
        clear_req_i = 1'b0; dump_req_i = 1'b0; dump_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", aBusy, 1);
        checkOutput("reset valid", aValid, 0);
        checkOutput("reset last", aLast, 0);
        checkOutput("reset data", aData, 0);
        checkOutput("reset idx", aIdx, 0);
        checkOutput("reset drop", aDrop, 0);
        rst = 1'b0;
        measureBusy(n);
        checkOutput("post-reset clear length", n, 64);

        $display("[TB] bucketing vectors");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].sample, 1);
            runDump(0, 0, -1);
            checkOutput($sformatf("bucket %0d bin", vecs[v].sample), bBins[vecs[v].expBin], 1);
            checkOutput($sformatf("bucket %0d nonzero bins", vecs[v].sample), nonzeroB(), 1);
            hist[vecs[v].expBin]++;
        end
        for (int b = 0; b < N_BINS; b++) begin
            checkOutput($sformatf("accumulated bin %0d", b), aBins[b], hist[b]);
        end

        $display("[TB] drops during dump");
        runDump(0, 10, -1);
        checkOutput("drop count A", aDrop, 10);
        checkOutput("drop count B", bDrop, 10);
        runDump(0, 0, -1);
        n = 0;
        for (int b = 0; b < N_BINS; b++) if (aBins[b] != hist[b]) n++;
        checkOutput("bins unchanged by drops", n, 0);
        checkOutput("B cleared and no drops binned", nonzeroB(), 0);

        $display("[TB] clear and dump together");
        clear_req_i = 1'b1;
        dump_req_i  = 1'b1;
        @(negedge clk);
        clear_req_i = 1'b0;
        dump_req_i  = 1'b0;
        measureBusy(n);
        checkOutput("clear busy length", n, 64);
        checkOutput("drop zeroed by clear", aDrop, 0);
        repeat (5) @(negedge clk);
        checkOutput("no dump after clear", aValid, 0);
        checkOutput("idle after clear", aBusy, 0);

        $display("[TB] forwarding");
        for (int i = 0; i < 8; i++) applyStimulus(fwdSeq[i], 1);
        runDump(0, 0, -1);
        checkOutput("fwd bin3", aBins[3], 6);
        checkOutput("fwd bin8", aBins[8], 2);
        checkOutput("fwd bin9", aBins[9], 0);
        checkOutput("fwd nonzero bins", nonzeroA(), 2);
        checkOutput("fwd B bin3", bBins[3], 6);

        $display("[TB] saturation");
        applyStimulus(100, 20);
        runDump(0, 0, -1);
        checkOutput("sat B bin29", bBins[29], 15);
        checkOutput("sat B drop", bDrop, 0);
        checkOutput("sat A bin29", aBins[29], 20);
        checkOutput("sat A bin3 kept", aBins[3], 6);

        $display("[TB] backpressure with clear-on-read");
        applyStimulus(0, 4);
        runDump(1, 0, -1);
        checkOutput("bp B bin0", bBins[0], 4);
        checkOutput("bp B nonzero bins", nonzeroB(), 1);
        checkOutput("bp A bin0", aBins[0], 4);
        runDump(0, 0, -1);
        checkOutput("second dump B zero", nonzeroB(), 0);
        checkOutput("A keeps bin0", aBins[0], 4);

        $display("[TB] reset mid-dump");
        runDump(0, 0, 20);
        rst = 1'b1;
        #1;
        checkOutput("abort valid A", aValid, 0);
        checkOutput("abort valid B", bValid, 0);
        checkOutput("abort busy", aBusy, 1);
        checkOutput("abort last", aLast, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        measureBusy(n);
        checkOutput("reset-abort clear length", n, 64);
        runDump(0, 0, -1);
        checkOutput("dump after reset zero", nonzeroA(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
